// File: rtl/clock_select_divider_if.sv
// Request/status bundle for clock_select_divider: key and select in,
// selected clock, rise strobe and switch status out.
interface clock_select_divider_if #(
  parameter int SEL_WIDTH = 2
);
  logic                 key_clock;
  logic [SEL_WIDTH-1:0] select;
  logic                 clock_out;
  logic                 clock_rise;
  logic [SEL_WIDTH-1:0] active_sel;
  logic                 switching;

  modport master (
    output key_clock, select,
    input  clock_out, clock_rise, active_sel, switching
  );

  modport slave (
    input  key_clock, select,
    output clock_out, clock_rise, active_sel, switching
  );
endinterface

// File: rtl/clock_select_divider.sv
// Glitch-free selector between a synchronised manual key and power-of-two divisor taps.
// Optional key debouncer enabled by defining KEY_DEBOUNCE_EN.
module clock_select_divider #(
  parameter int NUM_SRC         = 3,
  parameter int SEL_WIDTH       = 2,
  parameter int DIV_WIDTH       = 20,
  parameter int BASE_TAP        = 15,
  parameter int TAP_STEP        = 3,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input logic                   clock,
  input logic                   reset_n,
  clock_select_divider_if.slave bus
);

  typedef enum logic [1:0] {RUN, DRAIN, PARK} state_t;

  state_t                  state;
  logic [DIV_WIDTH-1:0]    divisor;
  logic                    key_m, key_s, key_src;
  logic [SEL_WIDTH-1:0]    sel_q, target, active_sel;
  logic                    clock_out, clock_rise;
  logic [NUM_SRC-1:0]      src;
  logic [2**SEL_WIDTH-1:0] src_pad;
  logic                    sel_ok, co_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      divisor <= '0;
      key_m   <= 1'b0;
      key_s   <= 1'b0;
      sel_q   <= '0;
    end else begin
      divisor <= divisor + 1'b1;
      key_m   <= bus.key_clock;
      key_s   <= key_m;
      sel_q   <= bus.select;
    end
  end

`ifdef KEY_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DB_W-1:0] db_cnt;
  logic            key_db;

  // key_db flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt <= '0;
      key_db <= 1'b0;
    end else if (key_s == key_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt <= '0;
      key_db <= key_s;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign key_src = key_db;
`else
  assign key_src = key_s;
`endif

  assign src[0] = key_src;
  for (genvar k = 1; k < NUM_SRC; k++) begin : g_tap
    assign src[k] = divisor[BASE_TAP + (k - 1) * TAP_STEP];
  end

  // Pad to the full select range so any select value indexes safely
  always_comb begin
    src_pad              = '0;
    src_pad[NUM_SRC-1:0] = src;
  end

  assign sel_ok  = ({1'b0, sel_q} < (SEL_WIDTH + 1)'(NUM_SRC));
  // DRAIN keeps following the old source; its first 0 sample is the park point
  assign co_next = (state == PARK) ? 1'b0 : src_pad[active_sel];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      target     <= '0;
      active_sel <= '0;
      clock_out  <= 1'b0;
      clock_rise <= 1'b0;
    end else begin
      clock_out  <= co_next;
      clock_rise <= co_next & ~clock_out;
      case (state)
        RUN: begin
          if (sel_ok && sel_q != active_sel) begin
            target <= sel_q;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          if (sel_ok && sel_q == active_sel) begin
            target <= sel_q;
            state  <= RUN;
          end else begin
            if (sel_ok) target <= sel_q;
            if (!src_pad[active_sel]) state <= PARK;
          end
        end
        PARK: begin
          // Retarget first; only hand over once the new source is sampled low
          if (sel_ok && sel_q != target) begin
            target <= sel_q;
          end else if (!src_pad[target]) begin
            active_sel <= target;
            state      <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.clock_out  = clock_out;
  assign bus.clock_rise = clock_rise;
  assign bus.active_sel = active_sel;
  assign bus.switching  = (state != RUN);

endmodule

// File: tb/tb_clock_select_divider.sv
// Directed bench for clock_select_divider: key path table, divide periods,
// glitch-free switch, abort/invalid select and asynchronous reset.
module tb_clock_select_divider;

  localparam int SEL_WIDTH = 2;
`ifdef KEY_DEBOUNCE_EN
  localparam int LAT = 4 + 3;
  localparam int KW  = 6;
`else
  localparam int LAT = 3;
  localparam int KW  = 5;
`endif

  logic clock;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  clock_select_divider_if #(.SEL_WIDTH(SEL_WIDTH)) bus ();

  clock_select_divider #(
    .NUM_SRC(3), .SEL_WIDTH(SEL_WIDTH), .DIV_WIDTH(8),
    .BASE_TAP(2), .TAP_STEP(1), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic key;
    logic co;
    logic rise;
  } vec_t;

  vec_t tbl[16];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_settle(input int want);
    int n;
    n = 0;
    while (!(int'(bus.active_sel) == want && !bus.switching) && n < 300) begin
      step();
      n++;
    end
    check("settle_active_sel", int'(bus.active_sel), want);
  endtask

  // Waits for a rise strobe, then counts the high and following low phase
  task automatic measure(output int hi, output int lo);
    int n;
    hi = 0;
    lo = 0;
    n  = 0;
    while (!bus.clock_rise && n < 200) begin
      step();
      n++;
    end
    if (!bus.clock_rise) begin
      hi = -1;
      lo = -1;
      return;
    end
    while (bus.clock_out && hi < 200) begin
      hi++;
      step();
    end
    while (!bus.clock_out && lo < 200) begin
      lo++;
      step();
    end
  endtask

  task automatic wait_rise();
    int n;
    n = 0;
    while (!bus.clock_rise && n < 200) begin
      step();
      n++;
    end
    check("wait_rise", int'(bus.clock_rise), 1);
  endtask

  initial begin
    int hi, lo, hi2, cnt, bad, sw;

    reset_n       = 1'b0;
    bus.key_clock = 1'b0;
    bus.select    = '0;

    for (int i = 0; i < 16; i++) begin
      tbl[i].key  = (i >= 1 && i <= KW);
      tbl[i].co   = (i >= LAT + 1 && i <= LAT + KW);
      tbl[i].rise = (i == LAT + 1);
    end

    // Reset state
    step();
    step();
    check("rst_clock_out", int'(bus.clock_out), 0);
    check("rst_clock_rise", int'(bus.clock_rise), 0);
    check("rst_active_sel", int'(bus.active_sel), 0);
    check("rst_switching", int'(bus.switching), 0);
    reset_n = 1'b1;

    // Key path: key set after edge i reaches clock_out LAT samples later
    for (int i = 0; i < 16; i++) begin
      step();
      bus.key_clock = tbl[i].key;
      check($sformatf("key_co[%0d]", i), int'(bus.clock_out), int'(tbl[i].co));
      check($sformatf("key_rise[%0d]", i), int'(bus.clock_rise), int'(tbl[i].rise));
      check($sformatf("key_sw[%0d]", i), int'(bus.switching), 0);
    end

`ifdef KEY_DEBOUNCE_EN
    // Bouncing key never survives the debouncer
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      bus.key_clock = (i == 0 || i == 2);
      if (bus.clock_out) cnt++;
    end
    check("bounce_highs", cnt, 0);
`endif

    // Divide by tap 2 then tap 3
    bus.select = 2'd1;
    wait_settle(1);
    measure(hi, lo);
    check("src1_high", hi, 4);
    check("src1_low", lo, 4);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.clock_rise) cnt++;
      step();
    end
    check("src1_rises_16", cnt, 2);
    bus.select = 2'd2;
    wait_settle(2);
    measure(hi, lo);
    check("src2_high", hi, 8);
    check("src2_low", lo, 8);

    // Glitch-free switch 1->2 requested in the first high cycle
    bus.select = 2'd1;
    wait_settle(1);
    wait_rise();
    bus.select = 2'd2;
    hi = 0; lo = 0; hi2 = 0; bad = 0; sw = 0;
    while (bus.clock_out && hi < 50) begin
      hi++;
      if (bus.active_sel != 2'd1) bad++;
      sw |= int'(bus.switching);
      step();
    end
    while (!bus.clock_out && lo < 100) begin
      lo++;
      if (bus.switching && bus.active_sel != 2'd1) bad++;
      sw |= int'(bus.switching);
      step();
    end
    check("sw_exit_active_sel", int'(bus.active_sel), 2);
    check("sw_exit_switching", int'(bus.switching), 0);
    while (bus.clock_out && hi2 < 50) begin
      hi2++;
      step();
    end
    check("sw_old_high", hi, 4);
    check("sw_low_min1", int'(lo >= 1), 1);
    check("sw_seen", sw, 1);
    check("sw_active_during", bad, 0);
    check("sw_new_high", hi2, 8);

    // Abort: 1->2->1 inside DRAIN keeps the src1 waveform intact
    bus.select = 2'd1;
    wait_settle(1);
    wait_rise();
    bus.select = 2'd2;
    hi = 1; lo = 0; bad = 0; sw = 0;
    step();
    bus.select = 2'd1;
    while (bus.clock_out && hi < 50) begin
      hi++;
      sw |= int'(bus.switching);
      if (bus.active_sel != 2'd1) bad++;
      step();
    end
    while (!bus.clock_out && lo < 50) begin
      lo++;
      sw |= int'(bus.switching);
      if (bus.active_sel != 2'd1) bad++;
      step();
    end
    check("abort_high", hi, 4);
    check("abort_low", lo, 4);
    check("abort_sw_seen", sw, 1);
    check("abort_active", bad, 0);
    check("abort_end_sw", int'(bus.switching), 0);
    measure(hi, lo);
    check("abort_next_high", hi, 4);

    // Invalid select is ignored
    bus.select = 2'd3;
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (bus.active_sel != 2'd1 || bus.switching) bad++;
    end
    check("invalid_ignored", bad, 0);
    measure(hi, lo);
    check("invalid_high", hi, 4);
    check("invalid_low", lo, 4);

    // Asynchronous reset while clock_out is high
    wait_rise();
    bus.select = 2'd0;
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_clock_out", int'(bus.clock_out), 0);
    check("arst_clock_rise", int'(bus.clock_rise), 0);
    check("arst_active_sel", int'(bus.active_sel), 0);
    check("arst_switching", int'(bus.switching), 0);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.clock_out || bus.switching) cnt++;
    end
    check("post_rst_idle", cnt, 0);
    check("post_rst_active", int'(bus.active_sel), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
